uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16: width of the baud divisor.
REQ-002 The block SHALL have parameter DEPTH, default 4: receive FIFO entries; power of two, at least 2.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port enable  input  1  receiver enable.
REQ-006 The block SHALL have port divisor  input  DIV_W  clk cycles per oversample tick.
REQ-007 The block SHALL have port tick  output  1  16x-oversample tick to the receiver datapath.
REQ-008 The block SHALL have port rx_done_tick  input  1  byte-complete pulse from the receiver datapath.
REQ-009 The block SHALL have port rx_dout  input  8  received byte; valid while rx_done_tick=1.
REQ-010 The block SHALL have port flush  input  1  synchronous FIFO clear.
REQ-011 The block SHALL have port rd_valid  output  1  FIFO not empty.
REQ-012 The block SHALL have port rd_data  output  8  FIFO head byte (show-ahead).
REQ-013 The block SHALL have port rd_ready  input  1  consumer accepts the head byte.
REQ-014 The block SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 The block SHALL have port overrun  output  1  sticky flag: a byte was dropped.
REQ-016 The block SHALL have port clr_overrun  input  1  clears overrun.

Function
REQ-017 The tick generator SHALL hold an internal counter cnt of width DIV_W, range 0..divisor-1.
REQ-018 While enable=0, cnt SHALL load 0 and tick SHALL be 0 on the next edge.
REQ-019 While enable=1, on each edge where cnt >= eff-1 (eff = max(divisor,1)), cnt SHALL load 0 and registered tick SHALL be 1 for exactly one cycle; otherwise cnt SHALL increment and tick SHALL be 0.
REQ-020 Tick period SHALL therefore be eff cycles; divisor 0 or 1 SHALL give tick=1 every cycle while enabled.
REQ-021 If divisor is lowered mid-count below cnt+1, the >= compare SHALL fire tick on the next edge with no wrap through 2^DIV_W.
REQ-022 The first tick after enable rises SHALL occur eff cycles after the first enabled edge.
REQ-023 A push SHALL occur when rx_done_tick=1, enable=1 and flush=0; rx_dout SHALL be written at the tail.
REQ-024 A pop SHALL occur when rd_valid=1, rd_ready=1 and flush=0; the head pointer SHALL advance.
REQ-025 rd_valid SHALL equal (count != 0); rd_data SHALL be mem[head] with zero latency from the pointers.
REQ-026 A byte pushed on edge N SHALL be visible on rd_data/rd_valid after edge N.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 count SHALL change by +1 on push only, -1 on pop only, and 0 on push+pop.
REQ-029 When full with push and no pop, the byte SHALL be discarded, count SHALL stay DEPTH, and overrun SHALL be set.
REQ-030 When full with push and pop in the same cycle, both SHALL occur with no overrun.
REQ-031 When empty, rd_ready SHALL be ignored, with no underflow and count held at 0.
REQ-032 rx_done_tick while enable=0 SHALL be ignored, with no push and no overrun.
REQ-033 flush SHALL zero the pointers and count on the next edge, overriding push and pop; overrun SHALL be unaffected.
REQ-034 clr_overrun SHALL clear overrun on the next edge; a simultaneous new overrun event SHALL win (overrun stays 1).
REQ-035 Deasserting enable SHALL retain FIFO contents and overrun, and reads SHALL continue.

Reset
REQ-036 On rst=0, immediately and independent of clk: cnt=0, tick=0, head=tail=0, count=0, rd_valid=0, overrun=0.
REQ-037 rd_data SHALL be don't-care while rd_valid=0; FIFO memory SHALL need no reset.
REQ-038 Reset asserted mid-count or with a full FIFO SHALL discard all state.
REQ-039 The first tick after release SHALL follow REQ-022.

Verification
REQ-040 Bench SHALL cover: divisor=5, enable=1 -> tick high 1 cycle every 5 cycles; divisor=0 -> tick every cycle; enable=0 -> tick=0 next cycle.
REQ-041 Bench SHALL cover: cnt=9 with divisor=20, then divisor changed to 4 -> tick on next edge, then every 4 cycles.
REQ-042 Bench SHALL cover: push 0x11,0x22,0x33,0x44 (DEPTH=4) with rd_ready=0, then push 0x55 -> count=4, overrun=1; pops return 0x11..0x44 in order; 0x55 never appears.
REQ-043 Bench SHALL cover: full FIFO with simultaneous push 0x66 and pop -> count stays 4, overrun=0, last popped byte 0x66.
REQ-044 Bench SHALL cover: clr_overrun coincident with an overflow push -> overrun stays 1; clr_overrun alone -> overrun=0 next cycle.
REQ-045 Bench SHALL cover: flush with count=3 plus a simultaneous push -> count=0 and rd_valid=0; async rst pulse mid-count -> tick, count and overrun all 0 before the next clk edge.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversample tick generator plus a small show-ahead receive FIFO
// with a sticky overrun flag, sitting between a UART receiver datapath and a
// byte consumer.
module uart_rx_ctrl #(
  parameter int DIV_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         divisor,
  output logic                     tick,
  input  logic                     rx_done_tick,
  input  logic [7:0]               rx_dout,
  input  logic                     flush,
  output logic                     rd_valid,
  output logic [7:0]               rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Tick generator
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] cnt_reg;
  logic             tick_reg;
  logic [DIV_W-1:0] eff;
  logic             cnt_wrap;

  // A divisor of 0 behaves like 1; the >= compare means a divisor lowered
  // below the running count fires on the next edge instead of wrapping.
  always_comb begin
    eff      = (divisor == '0) ? DIV_W'(1) : divisor;
    cnt_wrap = (cnt_reg >= (eff - DIV_W'(1)));
  end

  // Free-running oversample counter with a one-cycle registered tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (!enable) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (cnt_wrap) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b1;
    end else begin
      cnt_reg  <= cnt_reg + DIV_W'(1);
      tick_reg <= 1'b0;
    end
  end

  assign tick = tick_reg;

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic          overrun_reg, overrun_next;
  logic          push_req, full, pop, push, overflow;

  // Push/pop qualification, occupancy and overrun bookkeeping. A full FIFO
  // still accepts a byte when the head is popped in the same cycle.
  always_comb begin
    push_req     = rx_done_tick && enable && !flush;
    full         = (count_reg == FULL_CNT);
    pop          = (count_reg != '0) && rd_ready && !flush;
    push         = push_req && (!full || pop);
    overflow     = push_req && full && !pop;
    head_next    = head_reg;
    tail_next    = tail_reg;
    count_next   = count_reg;
    overrun_next = overrun_reg;

    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) tail_next = tail_reg + AW'(1);
      if (pop)  head_next = head_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end

    // A fresh overflow takes priority over a clear request.
    if (overflow)         overrun_next = 1'b1;
    else if (clr_overrun) overrun_next = 1'b0;
  end

  // Pointer, occupancy and overrun state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      head_reg    <= head_next;
      tail_reg    <= tail_next;
      count_reg   <= count_next;
      overrun_reg <= overrun_next;
    end
  end

  // Storage array; contents are only meaningful behind the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[tail_reg] <= rx_dout;
  end

  assign rd_valid = (count_reg != '0);
  assign rd_data  = mem[head_reg];
  assign count    = count_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl (DIV_W=16, DEPTH=4).
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] divisor;
  logic        tick;
  logic        rx_done_tick;
  logic [7:0]  rx_dout;
  logic        flush;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic [2:0]  count;
  logic        overrun;
  logic        clr_overrun;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(.DIV_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .divisor(divisor), .tick(tick),
    .rx_done_tick(rx_done_tick), .rx_dout(rx_dout), .flush(flush),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       dv;
    logic [7:0] dat;
    logic       fl;
    logic       rr;
    logic       clr;
    logic       e_tick;
    logic       e_vld;
    logic [7:0] e_data;
    logic [2:0] e_cnt;
    logic       e_ovr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic en, input logic dv, input logic [7:0] dat,
                              input logic fl, input logic rr, input logic clr,
                              input logic e_tick, input logic e_vld, input logic [7:0] e_data,
                              input logic [2:0] e_cnt, input logic e_ovr);
    vec_t v;
    v.en = en; v.dv = dv; v.dat = dat; v.fl = fl; v.rr = rr; v.clr = clr;
    v.e_tick = e_tick; v.e_vld = e_vld; v.e_data = e_data; v.e_cnt = e_cnt; v.e_ovr = e_ovr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge, then settle just after it for sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Inputs idle, reset asserted.
    rst = 1'b0; enable = 1'b0; divisor = 16'd0; rx_done_tick = 1'b0; rx_dout = 8'h00;
    flush = 1'b0; rd_ready = 1'b0; clr_overrun = 1'b0;
    #12;
    chk("reset.tick", 32'(tick), 32'd0);
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.rd_valid", 32'(rd_valid), 32'd0);
    chk("reset.overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    $display("reset released");

    // divisor=5: tick on every 5th enabled edge.
    divisor = 16'd5; enable = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cycle();
      chk($sformatf("div5.edge%0d.tick", k), 32'(tick), 32'((k % 5) == 0));
    end
    $display("div5 sequence done");

    // enable low: tick 0 on the next edge.
    enable = 1'b0;
    cycle();
    chk("disable.tick", 32'(tick), 32'd0);

    // divisor=0: tick every enabled cycle.
    divisor = 16'd0; enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk($sformatf("div0.edge%0d.tick", k), 32'(tick), 32'd1);
    end
    $display("div0 sequence done");

    // cnt reaches 9 with divisor=20, then divisor drops to 4.
    enable = 1'b0;
    cycle();
    divisor = 16'd20; enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      chk($sformatf("div20.edge%0d.tick", k), 32'(tick), 32'd0);
    end
    divisor = 16'd4;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      chk($sformatf("div4.edge%0d.tick", k), 32'(tick), 32'((k % 4) == 1));
    end
    $display("divisor lowered sequence done");
    enable = 1'b0;
    cycle();
    divisor = 16'd0;

    //            en  dv  dat    fl  rr  clr  tick vld data   cnt ovr
    vq.push_back(mk(1, 1, 8'h11, 0, 0, 0,   1,  1, 8'h11, 1, 0));
    vq.push_back(mk(1, 1, 8'h22, 0, 0, 0,   1,  1, 8'h11, 2, 0));
    vq.push_back(mk(1, 1, 8'h33, 0, 0, 0,   1,  1, 8'h11, 3, 0));
    vq.push_back(mk(1, 1, 8'h44, 0, 0, 0,   1,  1, 8'h11, 4, 0));
    vq.push_back(mk(1, 1, 8'h55, 0, 0, 0,   1,  1, 8'h11, 4, 1));
    vq.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1,  1, 8'h22, 3, 1));
    vq.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1,  1, 8'h33, 2, 1));
    vq.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1,  1, 8'h44, 1, 1));
    vq.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1,  0, 8'h00, 0, 1));
    vq.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1,  0, 8'h00, 0, 1));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, 1,   1,  0, 8'h00, 0, 0));
    vq.push_back(mk(1, 1, 8'h01, 0, 0, 0,   1,  1, 8'h01, 1, 0));
    vq.push_back(mk(1, 1, 8'h02, 0, 0, 0,   1,  1, 8'h01, 2, 0));
    vq.push_back(mk(1, 1, 8'h03, 0, 0, 0,   1,  1, 8'h01, 3, 0));
    vq.push_back(mk(1, 1, 8'h04, 0, 0, 0,   1,  1, 8'h01, 4, 0));
    vq.push_back(mk(1, 1, 8'h66, 0, 1, 0,   1,  1, 8'h02, 4, 0));
    vq.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1,  1, 8'h03, 3, 0));
    vq.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1,  1, 8'h04, 2, 0));
    vq.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1,  1, 8'h66, 1, 0));
    vq.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1,  0, 8'h00, 0, 0));
    vq.push_back(mk(1, 1, 8'h71, 0, 0, 0,   1,  1, 8'h71, 1, 0));
    vq.push_back(mk(1, 1, 8'h72, 0, 0, 0,   1,  1, 8'h71, 2, 0));
    vq.push_back(mk(1, 1, 8'h73, 0, 0, 0,   1,  1, 8'h71, 3, 0));
    vq.push_back(mk(1, 1, 8'h74, 0, 0, 0,   1,  1, 8'h71, 4, 0));
    vq.push_back(mk(1, 1, 8'h75, 0, 0, 1,   1,  1, 8'h71, 4, 1));
    vq.push_back(mk(1, 0, 8'h00, 0, 0, 1,   1,  1, 8'h71, 4, 0));
    vq.push_back(mk(1, 1, 8'h76, 0, 0, 0,   1,  1, 8'h71, 4, 1));
    vq.push_back(mk(1, 0, 8'h00, 0, 1, 0,   1,  1, 8'h72, 3, 1));
    vq.push_back(mk(1, 1, 8'h99, 1, 1, 0,   1,  0, 8'h00, 0, 1));
    vq.push_back(mk(1, 1, 8'hAA, 0, 0, 0,   1,  1, 8'hAA, 1, 1));
    vq.push_back(mk(0, 1, 8'hBB, 0, 0, 0,   0,  1, 8'hAA, 1, 1));
    vq.push_back(mk(0, 0, 8'h00, 0, 1, 0,   0,  0, 8'h00, 0, 1));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 1,   0,  0, 8'h00, 0, 0));

    foreach (vq[i]) begin
      enable = vq[i].en; rx_done_tick = vq[i].dv; rx_dout = vq[i].dat;
      flush = vq[i].fl; rd_ready = vq[i].rr; clr_overrun = vq[i].clr;
      cycle();
      chk($sformatf("vec%0d.tick", i), 32'(tick), 32'(vq[i].e_tick));
      chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vq[i].e_vld));
      chk($sformatf("vec%0d.count", i), 32'(count), 32'(vq[i].e_cnt));
      chk($sformatf("vec%0d.overrun", i), 32'(overrun), 32'(vq[i].e_ovr));
      if (vq[i].e_vld)
        chk($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vq[i].e_data));
      $display("vec%0d en=%0b push=%0b/%02h flush=%0b rd=%0b clr=%0b -> cnt=%0d ovr=%0b data=%02h",
               i, vq[i].en, vq[i].dv, vq[i].dat, vq[i].fl, vq[i].rr, vq[i].clr,
               count, overrun, rd_data);
    end
    rx_done_tick = 1'b0; rd_ready = 1'b0; clr_overrun = 1'b0; flush = 1'b0;

    // Async reset mid-count with a full FIFO and overrun set.
    divisor = 16'd3; enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      rx_done_tick = (k <= 5);
      rx_dout = 8'(8'hC0 + k);
      cycle();
    end
    rx_done_tick = 1'b0;
    chk("prerst.tick", 32'(tick), 32'd1);
    chk("prerst.count", 32'(count), 32'd4);
    chk("prerst.overrun", 32'(overrun), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("asyncrst.tick", 32'(tick), 32'd0);
    chk("asyncrst.count", 32'(count), 32'd0);
    chk("asyncrst.rd_valid", 32'(rd_valid), 32'd0);
    chk("asyncrst.overrun", 32'(overrun), 32'd0);
    #1 rst = 1'b1;
    $display("async reset pulse applied");
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk($sformatf("postrst.edge%0d.tick", k), 32'(tick), 32'(k == 3));
    end
    chk("postrst.count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
